// File: rtl/calc1_requester.sv
// calc1_requester
//
// Initiator end of one calc1 request/response port pair. Local logic hands over
// an operation with a valid/ready handshake. The operation goes onto the calc1
// request bus as two beats: the command with operand 1, then command 0 with
// operand 2. The block then waits for a response or a timeout, and holds the
// result until local logic consumes it. Only one operation is in flight at a
// time.
//
// Ports
//   c_clk          rising-edge clock
//   reset          asynchronous active-high reset
//   op_valid       local operation valid
//   op_ready       requester idle and able to take an operation (decoded from state)
//   op_cmd         calc1 command, forwarded unchanged
//   op_data1       operand 1
//   op_data2       operand 2
//   req_cmd_out    calc1 reqN_cmd_in
//   req_data_out   calc1 reqN_data_in
//   resp_in        calc1 out_respN (0 none, 1 ok, 2 overflow/invalid, 3 internal error)
//   resp_data_in   calc1 out_dataN
//   res_valid      result available
//   res_ready      local logic consumes the result
//   res_resp       captured response code, 0 on timeout
//   res_data       captured response data, 0 on timeout
//   res_timeout    result is a timeout (qualified by res_valid)
//   spurious_resp  sticky flag: a nonzero response arrived while not waiting for one
//
// TIMEOUT_CYCLES (2..1023) is the number of WAIT cycles without a response
// before the operation is abandoned.

module calc1_requester #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [0:3]  op_cmd,
  input  logic [0:31] op_data1,
  input  logic [0:31] op_data2,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  resp_in,
  input  logic [0:31] resp_data_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [0:1]  res_resp,
  output logic [0:31] res_data,
  output logic        res_timeout,
  output logic        spurious_resp
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [0:3]       r_reqCmd;
  logic [0:31]      r_reqData;
  logic [0:31]      r_data2;
  logic [CNT_W-1:0] r_count;
  logic             r_resValid;
  logic [0:1]       r_resResp;
  logic [0:31]      r_resData;
  logic             r_resTimeout;
  logic             r_spurious;

  logic             w_accept;
  logic             w_respSeen;
  logic             w_timeoutHit;

  assign w_respSeen   = (resp_in != 2'd0);
  assign w_accept     = (r_state == ST_IDLE) && op_valid;
  assign w_timeoutHit = (r_count == LAST_COUNT);

  assign op_ready      = (r_state == ST_IDLE);
  assign req_cmd_out   = r_reqCmd;
  assign req_data_out  = r_reqData;
  assign res_valid     = r_resValid;
  assign res_resp      = r_resResp;
  assign res_data      = r_resData;
  assign res_timeout   = r_resTimeout;
  assign spurious_resp = r_spurious;

  // State register.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode. A response in WAIT takes priority over the timeout,
  // so both conditions lead to HOLD. The datapath decides which result is stored.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (op_valid) w_nextState = ST_SEND1;
      ST_SEND1: w_nextState = ST_SEND2;
      ST_SEND2: w_nextState = ST_WAIT;
      ST_WAIT:  if (w_respSeen || w_timeoutHit) w_nextState = ST_HOLD;
      ST_HOLD:  if (res_ready) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Registered request bus, timeout counter, and result capture. The bus beat
  // for each state is loaded on the edge that enters that state. This keeps
  // the outputs registered while still matching the FSM timing.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_reqCmd     <= '0;
      r_reqData    <= '0;
      r_data2      <= '0;
      r_count      <= '0;
      r_resValid   <= 1'b0;
      r_resResp    <= '0;
      r_resData    <= '0;
      r_resTimeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_reqCmd  <= op_cmd;
            r_reqData <= op_data1;
            r_data2   <= op_data2;
          end
        end
        ST_SEND1: begin
          r_reqCmd  <= '0;
          r_reqData <= r_data2;
        end
        ST_SEND2: begin
          r_reqCmd  <= '0;
          r_reqData <= '0;
          r_count   <= '0;
        end
        ST_WAIT: begin
          if (w_respSeen) begin
            r_resResp    <= resp_in;
            r_resData    <= resp_data_in;
            r_resTimeout <= 1'b0;
            r_resValid   <= 1'b1;
          end else if (w_timeoutHit) begin
            r_resResp    <= '0;
            r_resData    <= '0;
            r_resTimeout <= 1'b1;
            r_resValid   <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
          end
        end
        default: begin
          r_reqCmd  <= '0;
          r_reqData <= '0;
        end
      endcase
    end
  end

  // Sticky flag for responses that arrive when none is expected. Only reset
  // clears it.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_spurious <= 1'b0;
    end else if (w_respSeen && (r_state != ST_WAIT)) begin
      r_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc1_requester.sv
// tb_calc1_requester
//
// Randomized bench for calc1_requester with a scoreboard.
// - The stimulus side pushes two entries for each operation: a bus/response
//   plan for the calc1 responder model, and the expected local result.
// - The responder process plays calc1 and checks the request bus beats and the
//   response timing.
// - The monitor process pops the expected result whenever res_valid appears
//   and compares against it.

module tb_calc1_requester;

  localparam int TO = 8;

  logic        c_clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [0:3]  op_cmd;
  logic [0:31] op_data1;
  logic [0:31] op_data2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  resp_in;
  logic [0:31] resp_data_in;
  logic        res_valid;
  logic        res_ready;
  logic [0:1]  res_resp;
  logic [0:31] res_data;
  logic        res_timeout;
  logic        spurious_resp;

  logic stimValid;
  logic noiseValid;
  assign op_valid = stimValid | noiseValid;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] d1;
    logic [31:0] d2;
    int          lat;
    logic [1:0]  resp;
    logic [31:0] data;
    int          abortAfter;
    bit          spur;
  } plan_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    bit          timeout;
    int          hold;
  } exp_t;

  plan_t planQ[$];
  exp_t  expQ[$];

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  bit expSpur = 1'b0;

  calc1_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .c_clk(c_clk),
    .reset(reset),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_cmd(op_cmd),
    .op_data1(op_data1),
    .op_data2(op_data2),
    .req_cmd_out(req_cmd_out),
    .req_data_out(req_data_out),
    .resp_in(resp_in),
    .resp_data_in(resp_data_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_resp(res_resp),
    .res_data(res_data),
    .res_timeout(res_timeout),
    .spurious_resp(spurious_resp)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural calc1: unsigned 32-bit arithmetic. Add carry-out and subtract
  // borrow report code 2 with zero data. Shifts use the low five bits of
  // operand 2. Unknown commands report code 2.
  function automatic void calcRef(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] resp, output logic [31:0] data);
    longint sum;
    case (cmd)
      4'd1: begin
        sum = longint'(a) + longint'(b);
        if (sum > 64'h0000_0000_FFFF_FFFF) begin resp = 2'd2; data = 32'd0; end
        else begin resp = 2'd1; data = sum[31:0]; end
      end
      4'd2: begin
        if (b > a) begin resp = 2'd2; data = 32'd0; end
        else begin resp = 2'd1; data = a - b; end
      end
      4'd5: begin resp = 2'd1; data = a << (b % 32); end
      4'd6: begin resp = 2'd1; data = a >> (b % 32); end
      default: begin resp = 2'd2; data = 32'd0; end
    endcase
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_opReady"}, 32'(op_ready), 32'd1);
    checkOutput({tag, "_reqCmd"}, 32'(req_cmd_out), 32'd0);
    checkOutput({tag, "_reqData"}, 32'(req_data_out), 32'd0);
    checkOutput({tag, "_resValid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_resResp"}, 32'(res_resp), 32'd0);
    checkOutput({tag, "_resData"}, 32'(res_data), 32'd0);
    checkOutput({tag, "_resTimeout"}, 32'(res_timeout), 32'd0);
    checkOutput({tag, "_spurious"}, 32'(spurious_resp), 32'd0);
  endtask

  // Issue one operation, then wait (bounded) until the monitor reports that it
  // has been consumed. A lat beyond TO means calc1 never answers.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2,
                               input int lat, input int hold, input bit spur, input bit forceErr);
    plan_t p;
    exp_t e;
    int startDone;
    int waited;
    calcRef(cmd, d1, d2, p.resp, p.data);
    if (forceErr) begin
      p.resp = 2'd3;
      p.data = $urandom;
    end
    p.cmd = cmd; p.d1 = d1; p.d2 = d2; p.lat = lat; p.abortAfter = 0; p.spur = spur;
    if (lat <= TO) begin
      e.resp = p.resp; e.data = p.data; e.timeout = 1'b0;
    end else begin
      e.resp = 2'd0; e.data = 32'd0; e.timeout = 1'b1;
    end
    e.hold = hold;
    planQ.push_back(p);
    expQ.push_back(e);
    startDone = doneCount;
    @(negedge c_clk);
    waited = 0;
    while (!op_ready && waited < 100) begin
      @(negedge c_clk);
      waited++;
    end
    checkOutput("opReadyBeforeIssue", 32'(op_ready), 32'd1);
    stimValid = 1'b1;
    op_cmd = cmd;
    op_data1 = d1;
    op_data2 = d2;
    @(posedge c_clk);
    #1 stimValid = 1'b0;
    waited = 0;
    while (doneCount == startDone && waited < 400) begin
      @(negedge c_clk);
      waited++;
    end
    if (doneCount == startDone) begin
      checkOutput("opCompletion", 32'(doneCount - startDone), 32'd1);
    end
  endtask

  // Start an operation, then pulse reset in SEND1 (abortAfter 1) or in WAIT
  // (abortAfter 2). All outputs must show reset values before the next clock edge.
  task automatic applyAbort(input int abortAfter);
    plan_t p;
    p.cmd = 4'd1; p.d1 = $urandom; p.d2 = $urandom; p.lat = 0;
    p.resp = 2'd0; p.data = 32'd0; p.abortAfter = abortAfter; p.spur = 1'b0;
    planQ.push_back(p);
    @(negedge c_clk);
    stimValid = 1'b1;
    op_cmd = p.cmd;
    op_data1 = p.d1;
    op_data2 = p.d2;
    @(posedge c_clk);
    #1 stimValid = 1'b0;
    repeat ((abortAfter == 1) ? 1 : 3) @(negedge c_clk);
    #1 reset = 1'b1;
    expSpur = 1'b0;
    #1 checkResetValues((abortAfter == 1) ? "rstSend1" : "rstWait");
    @(negedge c_clk);
    reset = 1'b0;
  endtask

  // calc1 responder model: check the two request beats, then answer after the
  // planned number of WAIT edges. The check confirms res_valid rises on exactly
  // the response edge, or on the last timeout edge when there is no answer.
  initial begin
    plan_t p;
    resp_in = 2'd0;
    resp_data_in = 32'd0;
    forever begin
      @(negedge c_clk);
      if (!reset && req_cmd_out != 4'd0) begin
        if (planQ.size() == 0) begin
          checkOutput("unexpectedBusCmd", 32'(req_cmd_out), 32'd0);
        end else begin
          p = planQ.pop_front();
          checkOutput("busCmd", 32'(req_cmd_out), 32'(p.cmd));
          checkOutput("busData1", req_data_out, p.d1);
          if (p.spur) begin
            resp_in = 2'd1;
            resp_data_in = $urandom;
            expSpur = 1'b1;
          end
          if (p.abortAfter != 1) begin
            @(negedge c_clk);
            resp_in = 2'd0;
            checkOutput("busCmd2", 32'(req_cmd_out), 32'd0);
            checkOutput("busData2", req_data_out, p.d2);
            if (p.spur) checkOutput("spuriousSet", 32'(spurious_resp), 32'd1);
            if (p.abortAfter != 2) begin
              @(negedge c_clk);
              checkOutput("busIdleCmd", 32'(req_cmd_out), 32'd0);
              checkOutput("busIdleData", req_data_out, 32'd0);
              if (p.lat <= TO) begin
                repeat (p.lat - 1) @(negedge c_clk);
                checkOutput("resNotEarly", 32'(res_valid), 32'd0);
                resp_in = p.resp;
                resp_data_in = p.data;
                @(negedge c_clk);
                resp_in = 2'd0;
                resp_data_in = $urandom;
                checkOutput("resOnResponseEdge", 32'(res_valid), 32'd1);
              end else begin
                repeat (TO - 1) @(negedge c_clk);
                checkOutput("timeoutNotEarly", 32'(res_valid), 32'd0);
                @(negedge c_clk);
                checkOutput("timeoutOnTime", 32'(res_valid), 32'd1);
              end
            end
          end
        end
      end
    end
  end

  // Result monitor: pop the expected result when res_valid shows up, then
  // optionally stall consumption. During the stall, check that the result
  // stays stable, op_ready stays low and the bus stays quiet while op_valid
  // toggles. After consumption, op_ready must return on the next cycle.
  initial begin
    exp_t e;
    logic [1:0]  heldResp;
    logic [31:0] heldData;
    res_ready = 1'b1;
    noiseValid = 1'b0;
    forever begin
      @(negedge c_clk);
      if (!reset && res_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResult", 32'(res_valid), 32'd0);
          e.hold = 0;
        end else begin
          e = expQ.pop_front();
          checkOutput("resResp", 32'(res_resp), 32'(e.resp));
          checkOutput("resData", res_data, e.data);
          checkOutput("resTimeout", 32'(res_timeout), 32'(e.timeout));
        end
        heldResp = res_resp;
        heldData = res_data;
        if (e.hold > 0) begin
          res_ready = 1'b0;
          for (int k = 0; k < e.hold; k++) begin
            noiseValid = 1'($urandom_range(0, 1));
            @(negedge c_clk);
            checkOutput("holdValid", 32'(res_valid), 32'd1);
            checkOutput("holdResp", 32'(res_resp), 32'(heldResp));
            checkOutput("holdData", res_data, heldData);
            checkOutput("holdOpReady", 32'(op_ready), 32'd0);
            checkOutput("holdBusCmd", 32'(req_cmd_out), 32'd0);
            checkOutput("holdBusData", req_data_out, 32'd0);
          end
          noiseValid = 1'b0;
          res_ready = 1'b1;
        end
        @(negedge c_clk);
        checkOutput("consumedValid", 32'(res_valid), 32'd0);
        checkOutput("opReadyAfterConsume", 32'(op_ready), 32'd1);
        checkOutput("spuriousSticky", 32'(spurious_resp), 32'(expSpur));
        doneCount++;
      end
    end
  end

  // Overall time limit in case something deadlocks.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] cmdList [5];
    logic [3:0] c;
    cmdList[0] = 4'd1; cmdList[1] = 4'd2; cmdList[2] = 4'd5; cmdList[3] = 4'd6; cmdList[4] = 4'd9;
    reset = 1'b1;
    stimValid = 1'b0;
    op_cmd = 4'd0;
    op_data1 = 32'd0;
    op_data2 = 32'd0;
    #2 checkResetValues("rstAsync");
    repeat (2) @(negedge c_clk);
    reset = 1'b0;
    @(negedge c_clk);
    checkResetValues("rstIdle");

    $display("[TB] directed: add, sub underflow, timeout, last-edge response");
    applyStimulus(4'd1, 32'h0000_0005, 32'h0000_0003, 4, 0, 1'b0, 1'b0);
    applyStimulus(4'd2, 32'h0000_0000, 32'h0000_0001, 2, 0, 1'b0, 1'b0);
    applyStimulus(4'd1, 32'h0000_0010, 32'h0000_0020, TO + 5, 0, 1'b0, 1'b0);
    applyStimulus(4'd5, 32'h0000_0003, 32'h0000_0004, TO, 0, 1'b0, 1'b0);
    applyStimulus(4'd6, 32'h8000_0000, 32'h0000_001F, 1, 0, 1'b0, 1'b0);

    $display("[TB] directed: hold stall, spurious response, reset aborts");
    applyStimulus(4'd1, 32'h1234_0000, 32'h0000_5678, 3, 10, 1'b0, 1'b0);
    applyStimulus(4'd2, 32'h0000_0100, 32'h0000_0001, 3, 0, 1'b1, 1'b0);
    applyAbort(2);
    applyAbort(1);
    applyStimulus(4'd1, 32'h0000_0005, 32'h0000_0003, 2, 0, 1'b0, 1'b0);

    $display("[TB] random operations");
    for (int n = 0; n < 24; n++) begin
      c = cmdList[$urandom_range(0, 4)];
      applyStimulus(c, $urandom, (c == 4'd2) ? 32'($urandom_range(0, 65535)) : $urandom,
                    $urandom_range(1, TO + 2), $urandom_range(0, 2), 1'b0,
                    ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(negedge c_clk);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("planEmpty", 32'(planQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
